// File: rtl/uart_pkg.sv
// Shared constants, state encodings and parity helper for the uart_xcvr transceiver.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    localparam int DEFAULT_CLOCKS_PER_BAUD = 868;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    // Parity bit for a payload whose bits XOR to data_xor; odd mode inverts it.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return data_xor ^ (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_xcvr_if.sv
// Byte-side handshake bundle of the UART transceiver; slave is the UART, master its consumer.
interface uart_xcvr_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] i_tx_data;
    logic                 i_tx_valid;
    logic                 o_tx_ready;
    logic [DATA_BITS-1:0] o_rx_data;
    logic                 o_rx_valid;
    logic                 o_rx_parity_err;
    logic                 o_rx_frame_err;
    logic                 o_rx_busy;
    logic                 o_tx_busy;

    modport master (
        output i_tx_data, i_tx_valid,
        input  o_tx_ready, o_rx_data, o_rx_valid, o_rx_parity_err,
        input  o_rx_frame_err, o_rx_busy, o_tx_busy
    );

    modport slave (
        input  i_tx_data, i_tx_valid,
        output o_tx_ready, o_rx_data, o_rx_valid, o_rx_parity_err,
        output o_rx_frame_err, o_rx_busy, o_tx_busy
    );
endinterface

// File: rtl/uart_baud_timer.sv
// Loadable baud down-counter: ticks for one cycle at zero and reloads a full bit period.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int TIMER_BITS      = 10
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  load,
    input  logic [TIMER_BITS-1:0] load_value,
    output logic                  tick
);
    localparam logic [TIMER_BITS-1:0] RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

    logic [TIMER_BITS-1:0] count;

    // A pending load suppresses the tick so an idle engine never sees a stray expiry.
    assign tick = !load && (count == '0);

    always_ff @(posedge clk) begin
        if (i_reset)
            count <= RELOAD;
        else if (load)
            count <= load_value;
        else if (count == '0)
            count <= RELOAD;
        else
            count <= count - 1'b1;
    end
endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART: independent RX and TX frame engines with configurable width, parity and stop bits.
module uart_xcvr
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int TIMER_BITS      = 10,
    parameter int DATA_BITS       = 8,
    parameter int PARITY          = PARITY_NONE,
    parameter int STOP_BITS       = 1
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_rx,
    output logic       o_tx,
    uart_xcvr_if.slave bus
);
    localparam int                    CNT_W      = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]      LAST_BIT   = CNT_W'(DATA_BITS - 1);
    localparam logic [TIMER_BITS-1:0] HALF_LOAD  = TIMER_BITS'(CLOCKS_PER_BAUD / 2 - 1);
    localparam logic [TIMER_BITS-1:0] FULL_LOAD  = TIMER_BITS'(CLOCKS_PER_BAUD - 1);
    localparam bit                    HAS_PARITY = (PARITY != PARITY_NONE);
    localparam logic                  LAST_STOP  = 1'(STOP_BITS - 1);

    logic [1:0]           rx_sync;
    logic                 rx_bit;
    rx_state_t            rx_state, rx_next;
    logic                 rx_load, rx_tick;
    logic [DATA_BITS-1:0] rx_shift;
    logic [CNT_W-1:0]     rx_count;
    logic                 rx_par;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, rx_perr_q, rx_ferr_q;

    tx_state_t            tx_state, tx_next;
    logic                 tx_load, tx_tick, tx_ready;
    logic [DATA_BITS-1:0] tx_shift;
    logic [CNT_W-1:0]     tx_count;
    logic                 tx_par, tx_stop_cnt;

    assign rx_bit = rx_sync[1];

    // Idle engines keep their timer preloaded, so the first bit period starts on the next cycle.
    uart_baud_timer #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD), .TIMER_BITS(TIMER_BITS)) rx_timer (
        .clk(clk), .i_reset(i_reset), .load(rx_load), .load_value(HALF_LOAD), .tick(rx_tick)
    );

    uart_baud_timer #(.CLOCKS_PER_BAUD(CLOCKS_PER_BAUD), .TIMER_BITS(TIMER_BITS)) tx_timer (
        .clk(clk), .i_reset(i_reset), .load(tx_load), .load_value(FULL_LOAD), .tick(tx_tick)
    );

    always_comb begin
        rx_next = rx_state;
        rx_load = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_load = 1'b1;
                if (!rx_bit) rx_next = RX_START;
            end
            RX_START:  if (rx_tick) rx_next = rx_bit ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_count == LAST_BIT) rx_next = HAS_PARITY ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
            // Leaving at the mid-bit sample lets a start edge in the stop bit's second half be caught.
            RX_STOP:   if (rx_tick) rx_next = rx_bit ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (rx_bit) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            rx_sync    <= 2'b11;
            rx_state   <= RX_IDLE;
            rx_shift   <= '0;
            rx_count   <= '0;
            rx_par     <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_perr_q  <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_sync    <= {rx_sync[0], i_rx};
            rx_state   <= rx_next;
            rx_valid_q <= 1'b0;
            if (rx_tick) begin
                case (rx_state)
                    RX_START:  rx_count <= '0;
                    RX_DATA: begin
                        rx_shift <= {rx_bit, rx_shift[DATA_BITS-1:1]};
                        rx_count <= rx_count + 1'b1;
                    end
                    RX_PARITY: rx_par <= rx_bit;
                    RX_STOP: begin
                        rx_data_q  <= rx_shift;
                        rx_valid_q <= 1'b1;
                        rx_ferr_q  <= ~rx_bit;
                        rx_perr_q  <= HAS_PARITY && (rx_par != parity_bit(^rx_shift, PARITY));
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        tx_next  = tx_state;
        tx_load  = 1'b0;
        tx_ready = 1'b0;
        o_tx     = 1'b1;
        case (tx_state)
            TX_IDLE: begin
                tx_load  = 1'b1;
                tx_ready = 1'b1;
                if (bus.i_tx_valid) tx_next = TX_START;
            end
            TX_START: begin
                o_tx = 1'b0;
                if (tx_tick) tx_next = TX_DATA;
            end
            TX_DATA: begin
                o_tx = tx_shift[0];
                if (tx_tick && tx_count == LAST_BIT) tx_next = HAS_PARITY ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: begin
                o_tx = tx_par;
                if (tx_tick) tx_next = TX_STOP;
            end
            TX_STOP:  if (tx_tick && tx_stop_cnt == LAST_STOP) tx_next = TX_IDLE;
            default:  tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            tx_state    <= TX_IDLE;
            tx_shift    <= '0;
            tx_count    <= '0;
            tx_par      <= 1'b0;
            tx_stop_cnt <= 1'b0;
        end else begin
            tx_state <= tx_next;
            if (tx_state == TX_IDLE && bus.i_tx_valid) begin
                tx_shift    <= bus.i_tx_data;
                tx_par      <= parity_bit(^bus.i_tx_data, PARITY);
                tx_count    <= '0;
                tx_stop_cnt <= 1'b0;
            end else if (tx_tick) begin
                if (tx_state == TX_DATA) begin
                    tx_shift <= tx_shift >> 1;
                    tx_count <= tx_count + 1'b1;
                end
                if (tx_state == TX_STOP) tx_stop_cnt <= ~tx_stop_cnt;
            end
        end
    end

    assign bus.o_tx_ready      = tx_ready;
    assign bus.o_tx_busy       = (tx_state != TX_IDLE);
    assign bus.o_rx_busy       = (rx_state != RX_IDLE);
    assign bus.o_rx_data       = rx_data_q;
    assign bus.o_rx_valid      = rx_valid_q;
    assign bus.o_rx_parity_err = rx_perr_q;
    assign bus.o_rx_frame_err  = rx_ferr_q;
endmodule
